// File: rtl/mips_pkg.sv
// Opcode/funct constants, ALU control codes and the main decoder for the single-cycle MIPS core.
// Build option: define MIPS_BRANCH_JUMP_EN to decode beq and j.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluSll = 4'b1000,
    AluSrl = 4'b1001,
    AluNor = 4'b1100
  } alu_ctl_e;

  localparam int unsigned CtlRegDst    = 11;
  localparam int unsigned CtlAluSrc    = 10;
  localparam int unsigned CtlMemToReg  = 9;
  localparam int unsigned CtlAluCtlLsb = 5;
  localparam int unsigned CtlMemWrite  = 4;
  localparam int unsigned CtlMemRead   = 3;
  localparam int unsigned CtlRegWrite  = 2;
  localparam int unsigned CtlBranch    = 1;
  localparam int unsigned CtlJump      = 0;

  // Field order matches the ControlLines bit layout.
  typedef struct packed {
    logic     reg_dst;
    logic     alu_src;
    logic     mem_to_reg;
    alu_ctl_e alu_ctl;
    logic     mem_write;
    logic     mem_read;
    logic     reg_write;
    logic     branch;
    logic     jump;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OpRtype: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          FnAdd:   c.alu_ctl = AluAdd;
          FnSub:   c.alu_ctl = AluSub;
          FnAnd:   c.alu_ctl = AluAnd;
          FnOr:    c.alu_ctl = AluOr;
          FnNor:   c.alu_ctl = AluNor;
          FnSlt:   c.alu_ctl = AluSlt;
          FnSll:   c.alu_ctl = AluSll;
          FnSrl:   c.alu_ctl = AluSrl;
          default: c = '0;
        endcase
      end
      OpAddi: begin
        c.alu_src   = 1'b1;
        c.alu_ctl   = AluAdd;
        c.reg_write = 1'b1;
      end
      OpAndi: begin
        c.alu_src   = 1'b1;
        c.alu_ctl   = AluAnd;
        c.reg_write = 1'b1;
      end
      OpOri: begin
        c.alu_src   = 1'b1;
        c.alu_ctl   = AluOr;
        c.reg_write = 1'b1;
      end
      OpLw: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_ctl    = AluAdd;
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
      end
      OpSw: begin
        c.alu_src   = 1'b1;
        c.alu_ctl   = AluAdd;
        c.mem_write = 1'b1;
      end
      OpBeq: begin
`ifdef MIPS_BRANCH_JUMP_EN
        c.alu_ctl = AluSub;
        c.branch  = 1'b1;
`endif
      end
      OpJ: begin
`ifdef MIPS_BRANCH_JUMP_EN
        c.jump = 1'b1;
`endif
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, async clear.
// Register 0 always reads zero and ignores writes.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS core with loadable instruction memory and a small data memory.
// Build option: MIPS_BRANCH_JUMP_EN enables beq/j and the branch/jump next-PC mux.
module mips_single_cycle
  import mips_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] WriteData,
  input  logic        WriteEnable,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] DataMEMtoReg,
  output logic [31:0] ALUresult,
  output logic [11:0] ControlLines
);

  logic [31:0] imem [256];
  logic [31:0] dmem [64];

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, waddr;
  logic [15:0] imm;
  logic [31:0] imm_ext, alu_b, alu_y, dmem_rdata;
  ctrl_t       ctrl;
  alu_ctl_e    alu_ctl;
  logic        reg_dst, alu_src, mem_to_reg, mem_write, mem_read, reg_write, branch, jump;
  logic        reg_write_en, mem_write_en, zero, overflow, unused_flags;

  assign instr    = imem[pc[9:2]];
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];

  assign ctrl         = decode(opcode, funct);
  assign ControlLines = ctrl;

  assign reg_dst    = ControlLines[CtlRegDst];
  assign alu_src    = ControlLines[CtlAluSrc];
  assign mem_to_reg = ControlLines[CtlMemToReg];
  assign alu_ctl    = alu_ctl_e'(ControlLines[CtlAluCtlLsb +: 4]);
  assign mem_write  = ControlLines[CtlMemWrite];
  assign mem_read   = ControlLines[CtlMemRead];
  assign reg_write  = ControlLines[CtlRegWrite];
  assign branch     = ControlLines[CtlBranch];
  assign jump       = ControlLines[CtlJump];

  // Loading instructions must not disturb architectural state.
  assign reg_write_en = reg_write & ~WriteEnable;
  assign mem_write_en = mem_write & ~WriteEnable;
  assign waddr        = reg_dst ? rd : rt;

  mips_regfile u_regfile (
    .clk    (Clk),
    .rst    (Reset),
    .we     (reg_write_en),
    .raddr1 (rs),
    .raddr2 (rt),
    .waddr  (waddr),
    .wdata  (DataMEMtoReg),
    .rdata1 (ReadData1),
    .rdata2 (ReadData2)
  );

  // Logical immediates are zero-extended, everything else sign-extended.
  assign imm_ext = ((opcode == OpAndi) || (opcode == OpOri)) ? {16'h0000, imm}
                                                             : {{16{imm[15]}}, imm};
  assign alu_b   = alu_src ? imm_ext : ReadData2;

  always_comb begin
    alu_y    = '0;
    overflow = 1'b0;
    case (alu_ctl)
      AluAnd: alu_y = ReadData1 & alu_b;
      AluOr:  alu_y = ReadData1 | alu_b;
      AluAdd: begin
        alu_y    = ReadData1 + alu_b;
        overflow = (ReadData1[31] == alu_b[31]) && (alu_y[31] != ReadData1[31]);
      end
      AluSub: begin
        alu_y    = ReadData1 - alu_b;
        overflow = (ReadData1[31] != alu_b[31]) && (alu_y[31] != ReadData1[31]);
      end
      AluSlt: alu_y = {31'd0, $signed(ReadData1) < $signed(alu_b)};
      AluNor: alu_y = ~(ReadData1 | alu_b);
      AluSll: alu_y = alu_b << shamt;
      AluSrl: alu_y = alu_b >> shamt;
      default: alu_y = '0;
    endcase
  end

  assign ALUresult    = alu_y;
  assign zero         = (alu_y == 32'd0);
  assign dmem_rdata   = mem_read ? dmem[ALUresult[7:2]] : 32'd0;
  assign DataMEMtoReg = mem_to_reg ? dmem_rdata : ALUresult;

  // Overflow is informational only; branch/jump go unused when the option is off.
  assign unused_flags = ^{overflow, zero, branch, jump};

  always_comb begin
    pc_next = pc_plus4;
`ifdef MIPS_BRANCH_JUMP_EN
    if (!WriteEnable) begin
      if (jump) begin
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (branch && zero) begin
        pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (WriteEnable && !Reset) begin
      imem[pc[9:2]] <= WriteData;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_write_en && !Reset) begin
      dmem[ALUresult[7:2]] <= ReadData2;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle.sv
// Scoreboard bench for mips_single_cycle: loads a program, runs it and checks every cycle.
// Expectations follow MIPS_BRANCH_JUMP_EN when it is defined for the build.
module tb_mips_single_cycle;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] WriteData = '0;
  logic        WriteEnable = 1'b0;
  logic [31:0] ReadData1, ReadData2, DataMEMtoReg, ALUresult;
  logic [11:0] ControlLines;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu;
    logic [31:0] wb;
    logic [11:0] ctl;
  } exp_t;

  exp_t sb[$];

  logic [31:0] prog [24] = '{
    32'h20010005, 32'h20020007, 32'h00221820, 32'h00222022, 32'h0022282A, 32'h00003827,
    32'hAC030008, 32'h8C060008, 32'h20000009, 32'h00064020, 32'h10210002, 32'h20090001,
    32'h20090002, 32'h20090003, 32'h000250C0, 32'h00045902, 32'h308CF0F0, 32'h340D8001,
    32'h200EFFFF, 32'h08000016, 32'h200F0011, 32'h200F0022, 32'h012F8025, 32'hFC000000
  };

  mips_single_cycle dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .WriteData    (WriteData),
    .WriteEnable  (WriteEnable),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .DataMEMtoReg (DataMEMtoReg),
    .ALUresult    (ALUresult),
    .ControlLines (ControlLines)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic void add_exp(input string name, input logic [31:0] rd1,
                                  input logic [31:0] rd2, input logic [31:0] alu,
                                  input logic [31:0] wb, input logic [11:0] ctl);
    exp_t e;
    e.name = name; e.rd1 = rd1; e.rd2 = rd2; e.alu = alu; e.wb = wb; e.ctl = ctl;
    sb.push_back(e);
  endfunction

  // One entry per executed instruction, in execution order from PC=0 with cleared registers.
  function automatic void push_expect();
    add_exp("addi1",   0, 0,  5,  5, 12'h444);
    add_exp("addi2",   0, 0,  7,  7, 12'h444);
    add_exp("add",     5, 7, 12, 12, 12'h844);
    add_exp("sub",     5, 7, 32'hFFFFFFFE, 32'hFFFFFFFE, 12'h8C4);
    add_exp("slt",     5, 7,  1,  1, 12'h8E4);
    add_exp("nor",     0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h984);
    add_exp("sw",      0, 12, 8,  8, 12'h450);
    add_exp("lw",      0, 0,  8, 12, 12'h64C);
    add_exp("addi_r0", 0, 0,  9,  9, 12'h444);
    add_exp("read_r0", 0, 12, 12, 12, 12'h844);
`ifdef MIPS_BRANCH_JUMP_EN
    add_exp("beq",     5, 5,  0,  0, 12'h0C2);
    add_exp("addi9_3", 0, 0,  3,  3, 12'h444);
`else
    add_exp("beq_nop", 5, 5,  5,  5, 12'h000);
    add_exp("addi9_1", 0, 0,  1,  1, 12'h444);
    add_exp("addi9_2", 0, 1,  2,  2, 12'h444);
    add_exp("addi9_3", 0, 2,  3,  3, 12'h444);
`endif
    add_exp("sll",     0, 7, 56, 56, 12'h904);
    add_exp("srl",     0, 32'hFFFFFFFE, 32'h0FFFFFFF, 32'h0FFFFFFF, 12'h924);
    add_exp("andi",    32'hFFFFFFFE, 0, 32'h0000F0F0, 32'h0000F0F0, 12'h404);
    add_exp("ori",     0, 0, 32'h00008001, 32'h00008001, 12'h424);
    add_exp("addi_ng", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h444);
`ifdef MIPS_BRANCH_JUMP_EN
    add_exp("j",       0, 0,  0,  0, 12'h001);
    add_exp("or",      3, 0,  3,  3, 12'h824);
`else
    add_exp("j_nop",   0, 0,  0,  0, 12'h000);
    add_exp("addi15a", 0, 0, 32'h11, 32'h11, 12'h444);
    add_exp("addi15b", 0, 32'h11, 32'h22, 32'h22, 12'h444);
    add_exp("or",      3, 32'h22, 32'h23, 32'h23, 12'h824);
`endif
    add_exp("unknown", 0, 0,  0,  0, 12'h000);
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    checks += 5;
    if (ControlLines !== 12'h904) begin
      failures++; $display("FAIL reset_ctl got %h want %h", ControlLines, 12'h904);
    end
    if (ReadData1 !== 32'd0) begin
      failures++; $display("FAIL reset_rd1 got %h want 0", ReadData1);
    end
    if (ReadData2 !== 32'd0) begin
      failures++; $display("FAIL reset_rd2 got %h want 0", ReadData2);
    end
    if (ALUresult !== 32'd0) begin
      failures++; $display("FAIL reset_alu got %h want 0", ALUresult);
    end
    if (DataMEMtoReg !== 32'd0) begin
      failures++; $display("FAIL reset_wb got %h want 0", DataMEMtoReg);
    end
  endtask

  task automatic test_program();
    exp_t e;
    @(negedge Clk);
    Reset = 1'b0;
    WriteEnable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      WriteData = prog[i];
      @(negedge Clk);
    end
    WriteEnable = 1'b0;
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #1;
    push_expect();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks += 5;
      if (ReadData1 !== e.rd1) begin
        failures++; $display("FAIL %s rd1 got %h want %h", e.name, ReadData1, e.rd1);
      end
      if (ReadData2 !== e.rd2) begin
        failures++; $display("FAIL %s rd2 got %h want %h", e.name, ReadData2, e.rd2);
      end
      if (ALUresult !== e.alu) begin
        failures++; $display("FAIL %s alu got %h want %h", e.name, ALUresult, e.alu);
      end
      if (DataMEMtoReg !== e.wb) begin
        failures++; $display("FAIL %s wb got %h want %h", e.name, DataMEMtoReg, e.wb);
      end
      if (ControlLines !== e.ctl) begin
        failures++; $display("FAIL %s ctl got %h want %h", e.name, ControlLines, e.ctl);
      end
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic test_reset_rerun();
    exp_t e;
    int   steps;
    // Reset held across load-mode edges: imem[0] and PC must stay untouched.
    @(negedge Clk);
    Reset = 1'b1;
    WriteEnable = 1'b1;
    WriteData = 32'hDEADBEEF;
    repeat (3) @(negedge Clk);
    WriteEnable = 1'b0;
    #1;
    checks += 3;
    if (ControlLines !== 12'h444) begin
      failures++; $display("FAIL rst_load_ctl got %h want %h", ControlLines, 12'h444);
    end
    if (ReadData2 !== 32'd0) begin
      failures++; $display("FAIL rst_load_r1 got %h want 0", ReadData2);
    end
    if (ALUresult !== 32'd5) begin
      failures++; $display("FAIL rst_load_alu got %h want 5", ALUresult);
    end
    Reset = 1'b0;
    #1;
    for (int phase = 0; phase < 2; phase++) begin
      push_expect();
      steps = (phase == 0) ? 6 : sb.size();
      for (int k = 0; k < steps; k++) begin
        e = sb.pop_front();
        checks += 5;
        if (ReadData1 !== e.rd1) begin
          failures++; $display("FAIL re%0d_%s rd1 got %h want %h", phase, e.name, ReadData1, e.rd1);
        end
        if (ReadData2 !== e.rd2) begin
          failures++; $display("FAIL re%0d_%s rd2 got %h want %h", phase, e.name, ReadData2, e.rd2);
        end
        if (ALUresult !== e.alu) begin
          failures++; $display("FAIL re%0d_%s alu got %h want %h", phase, e.name, ALUresult, e.alu);
        end
        if (DataMEMtoReg !== e.wb) begin
          failures++; $display("FAIL re%0d_%s wb got %h want %h", phase, e.name, DataMEMtoReg, e.wb);
        end
        if (ControlLines !== e.ctl) begin
          failures++; $display("FAIL re%0d_%s ctl got %h want %h", phase, e.name, ControlLines, e.ctl);
        end
        @(negedge Clk);
        #1;
      end
      if (phase == 0) begin
        // Mid-cycle reset: PC and registers must clear without a clock edge.
        Reset = 1'b1;
        #1;
        checks += 4;
        if (ControlLines !== 12'h444) begin
          failures++; $display("FAIL async_ctl got %h want %h", ControlLines, 12'h444);
        end
        if (ReadData2 !== 32'd0) begin
          failures++; $display("FAIL async_r1 got %h want 0", ReadData2);
        end
        if (ALUresult !== 32'd5) begin
          failures++; $display("FAIL async_alu got %h want 5", ALUresult);
        end
        if (DataMEMtoReg !== 32'd5) begin
          failures++; $display("FAIL async_wb got %h want 5", DataMEMtoReg);
        end
        sb.delete();
        @(negedge Clk);
        Reset = 1'b0;
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_reset_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
